// File: rtl/ysyx_24080006_pkg.sv
// Shared constants and types for the execute-stage M-mode CSR unit.
package ysyx_24080006_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  typedef enum logic [1:0] {
    CSR_RW = 2'b01,
    CSR_RS = 2'b10,
    CSR_RC = 2'b11
  } csr_op_e;

  typedef struct packed {
    logic              csr_enable;
    csr_op_e           csr_op;
    logic              csr_imm;
    logic [4:0]        csr_uimm;
    logic [CSR_AW-1:0] csr_addr;
  } csr_set_t;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MVENDORID = 12'hF11;
  localparam logic [CSR_AW-1:0] CSR_MARCHID   = 12'hF12;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH   = 12'hB80;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam logic [XLEN-1:0] MVENDORID_VAL  = 32'h7973_7978;
  localparam logic [XLEN-1:0] MARCHID_VAL    = 32'h016F_6E86;
  localparam logic [XLEN-1:0] MCAUSE_ECALL_M = 32'd11;

  // Read-modify-write combine for CSRRW/CSRRS/CSRRC and their immediate forms.
  function automatic logic [XLEN-1:0] csr_alu(input csr_op_e op,
                                              input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] src);
    case (op)
      CSR_RW:  return src;
      CSR_RS:  return old | src;
      CSR_RC:  return old & ~src;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/exu_csr_if.sv
// EX-control to CSR-unit bundle: commit pulse, instruction decode and read data.
interface exu_csr_if;
  import ysyx_24080006_pkg::*;

  logic            valid_i;
  logic            ecall;
  logic            mret;
  logic [XLEN-1:0] pc;
  csr_set_t        csr_set;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;

  modport master (output valid_i, ecall, mret, pc, csr_set, csr_wdata,
                  input  csr_rdata);
  modport slave  (input  valid_i, ecall, mret, pc, csr_set, csr_wdata,
                  output csr_rdata);
endinterface

// File: rtl/exu_csr.sv
// Machine-mode CSR file with combinational read and ecall/mret side effects.
// Define CSR_COUNTER_EN to build the 64-bit mcycle/mcycleh counter.
module exu_csr
  import ysyx_24080006_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  exu_csr_if.slave  csr_bus
);

  logic            mie_q, mpie_q;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [XLEN-1:0] mstatus_c, addr_rdata_c, src_c, wval_c;
  logic            csr_we_c;
`ifdef CSR_COUNTER_EN
  logic [63:0]     mcycle_q;
`endif

  // Only MIE/MPIE are stored; MPP reads as machine mode.
  always_comb begin
    mstatus_c                                = '0;
    mstatus_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_c[MSTATUS_MPIE]                  = mpie_q;
    mstatus_c[MSTATUS_MIE]                   = mie_q;
  end

  always_comb begin
    addr_rdata_c = '0;
    case (csr_bus.csr_set.csr_addr)
      CSR_MSTATUS:   addr_rdata_c = mstatus_c;
      CSR_MTVEC:     addr_rdata_c = mtvec_q;
      CSR_MSCRATCH:  addr_rdata_c = mscratch_q;
      CSR_MEPC:      addr_rdata_c = mepc_q;
      CSR_MCAUSE:    addr_rdata_c = mcause_q;
      CSR_MVENDORID: addr_rdata_c = MVENDORID_VAL;
      CSR_MARCHID:   addr_rdata_c = MARCHID_VAL;
`ifdef CSR_COUNTER_EN
      CSR_MCYCLE:    addr_rdata_c = mcycle_q[31:0];
      CSR_MCYCLEH:   addr_rdata_c = mcycle_q[63:32];
`endif
      default:       addr_rdata_c = '0;
    endcase
  end

  // Trap entry/return targets take over the read port for the next-PC mux.
  assign csr_bus.csr_rdata = csr_bus.ecall ? mtvec_q :
                             csr_bus.mret  ? mepc_q  : addr_rdata_c;

  assign src_c    = csr_bus.csr_set.csr_imm ? XLEN'({27'd0, csr_bus.csr_set.csr_uimm})
                                            : csr_bus.csr_wdata;
  assign wval_c   = csr_alu(csr_bus.csr_set.csr_op, csr_bus.csr_rdata, src_c);
  assign csr_we_c = csr_bus.valid_i & ~csr_bus.ecall & ~csr_bus.mret
                  & csr_bus.csr_set.csr_enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (csr_bus.valid_i) begin
      if (csr_bus.ecall) begin
        mepc_q   <= csr_bus.pc;
        mcause_q <= MCAUSE_ECALL_M;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (csr_bus.mret) begin
        mie_q    <= mpie_q;
        mpie_q   <= 1'b1;
      end else if (csr_we_c) begin
        case (csr_bus.csr_set.csr_addr)
          CSR_MSTATUS: begin
            mie_q  <= wval_c[MSTATUS_MIE];
            mpie_q <= wval_c[MSTATUS_MPIE];
          end
          CSR_MTVEC:    mtvec_q    <= wval_c;
          CSR_MSCRATCH: mscratch_q <= wval_c;
          CSR_MEPC:     mepc_q     <= {wval_c[XLEN-1:1], 1'b0};
          CSR_MCAUSE:   mcause_q   <= wval_c;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTER_EN
  // A committed write to either half suppresses the increment for the whole counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcycle_q <= '0;
    end else if (csr_we_c && csr_bus.csr_set.csr_addr == CSR_MCYCLE) begin
      mcycle_q[31:0]  <= wval_c;
    end else if (csr_we_c && csr_bus.csr_set.csr_addr == CSR_MCYCLEH) begin
      mcycle_q[63:32] <= wval_c;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exu_csr.sv
// Scoreboard bench for exu_csr: directed spec scenarios then randomized traffic
// against a per-instruction architectural model.
module tb_exu_csr;
  import ysyx_24080006_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exu_csr_if bus();
  exu_csr dut (.clock(clk), .reset(rst), .csr_bus(bus));

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic chk_pend = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Architectural model state.
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic        m_mie, m_mpie;
  logic [63:0] m_cyc;

  function automatic logic [31:0] m_csr(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hF11: return 32'h7973_7978;
      12'hF12: return 32'h016F_6E86;
`ifdef CSR_COUNTER_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic ec, input logic mr, input logic [11:0] a);
    if (ec) return m_mtvec;
    if (mr) return m_mepc;
    return m_csr(a);
  endfunction

  task automatic m_reset();
    m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_mie = 0; m_mpie = 0; m_cyc = 0;
  endtask

  task automatic m_commit(input logic v, input logic ec, input logic mr, input logic [31:0] pcv,
                          input logic en, input logic [1:0] op, input logic imm,
                          input logic [4:0] uimm, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] old, src, nv;
`ifdef CSR_COUNTER_EN
    logic cyc_written;
    cyc_written = 1'b0;
`endif
    old = m_read(ec, mr, a);
    src = imm ? {27'd0, uimm} : wd;
    if (op == 2'b01)      nv = src;
    else if (op == 2'b10) nv = old | src;
    else                  nv = old & ~src;
    if (v && ec) begin
      m_mepc = pcv; m_mcause = 32'd11; m_mpie = m_mie; m_mie = 1'b0;
    end else if (v && mr) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end else if (v && en) begin
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec    = nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & 32'hFFFF_FFFE;
        12'h342: m_mcause   = nv;
`ifdef CSR_COUNTER_EN
        12'hB00: begin m_cyc[31:0]  = nv; cyc_written = 1'b1; end
        12'hB80: begin m_cyc[63:32] = nv; cyc_written = 1'b1; end
`endif
        default: ;
      endcase
    end
`ifdef CSR_COUNTER_EN
    if (!cyc_written) m_cyc = m_cyc + 64'd1;
`endif
  endtask

  // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic r, input logic v, input logic ec, input logic mr,
                       input logic [31:0] pcv, input logic en, input logic [1:0] op,
                       input logic imm, input logic [4:0] uimm, input logic [11:0] a,
                       input logic [31:0] wd, input logic do_chk, input string name);
    exp_t e;
    rst = r; bus.valid_i = v; bus.ecall = ec; bus.mret = mr; bus.pc = pcv;
    bus.csr_set.csr_enable = en; bus.csr_set.csr_op = csr_op_e'(op);
    bus.csr_set.csr_imm = imm; bus.csr_set.csr_uimm = uimm; bus.csr_set.csr_addr = a;
    bus.csr_wdata = wd;
    if (do_chk) begin
      e.exp = m_read(ec, mr, a); e.name = name;
      sb.push_back(e);
    end
    chk_pend = do_chk;
    @(posedge clk);
    if (r) m_reset();
    else   m_commit(v, ec, mr, pcv, en, op, imm, uimm, a, wd);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string name);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b01, 1'b0, 5'd0, a, 32'h0, 1'b1, name);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input string name);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, op, 1'b0, 5'd0, a, wd, 1'b1, name);
  endtask

  // Monitor: compare csr_rdata mid-cycle whenever the stimulus posted an expectation.
  always @(negedge clk) begin
    if (chk_pend) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: no expectation queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.csr_rdata === e.exp) n_pass++;
        else $display("FAIL %s: csr_rdata=%h expected=%h", e.name, bus.csr_rdata, e.exp);
      end
    end
  end

  initial begin
    logic [11:0] addrs [11];
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF11,
              12'hF12, 12'hB00, 12'hB80, 12'h7C0, 12'h000};
    rst = 1'b1; bus.valid_i = 1'b0; bus.ecall = 1'b0; bus.mret = 1'b0; bus.pc = '0;
    bus.csr_set = '0; bus.csr_set.csr_op = CSR_RW; bus.csr_wdata = '0;
    m_reset();
    @(posedge clk); #1;

    // Reads during reset and after release.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b01, 1'b0, 5'd0, 12'h300, 32'h0, 1'b1, "rst_mstatus_in_reset");
    rd(12'h300, "rst_mstatus");
    rd(12'hF11, "mvendorid");
    rd(12'hF12, "marchid");

    // CSRRW mtvec, then a non-committed repeat.
    wr(2'b01, 12'h305, 32'h8000_0100, "mtvec_rw_old");
    rd(12'h305, "mtvec_after_rw");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'b01, 1'b0, 5'd0, 12'h305, 32'h1234, 1'b1, "mtvec_novalid");
    rd(12'h305, "mtvec_unchanged");

    // Set/clear/immediate on mscratch.
    wr(2'b01, 12'h340, 32'h0000_F0F0, "mscratch_preset");
    wr(2'b10, 12'h340, 32'h0000_0F0F, "mscratch_rs_old");
    rd(12'h340, "mscratch_rs");
    wr(2'b11, 12'h340, 32'h0000_00FF, "mscratch_rc_old");
    rd(12'h340, "mscratch_rc");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 2'b01, 1'b1, 5'd5, 12'h340, 32'hDEAD_BEEF, 1'b1, "mscratch_rwi_old");
    rd(12'h340, "mscratch_rwi");

    // ecall / mret round trip with MIE set.
    wr(2'b10, 12'h300, 32'h0000_0008, "mstatus_set_mie");
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0040, 1'b0, 2'b01, 1'b0, 5'd0, 12'h340, 32'h0, 1'b1, "ecall_rdata");
    rd(12'h341, "ecall_mepc");
    rd(12'h342, "ecall_mcause");
    rd(12'h300, "ecall_mstatus");
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 2'b01, 1'b0, 5'd0, 12'h300, 32'h0, 1'b1, "mret_rdata");
    rd(12'h300, "mret_mstatus");

    // ecall+mret+csr write together: ecall wins, write dropped.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0080, 1'b1, 2'b01, 1'b0, 5'd0, 12'h340, 32'h5555_5555, 1'b1, "ecall_mret_rdata");
    rd(12'h340, "write_dropped_on_ecall");
    rd(12'h341, "ecall_mret_mepc");

    // Read-only and unimplemented addresses, mepc alignment.
    wr(2'b01, 12'hF11, 32'h1234, "ro_write_old");
    wr(2'b01, 12'h7C0, 32'h1234, "unimp_write_old");
    rd(12'hF11, "ro_unchanged");
    rd(12'h7C0, "unimp_reads_zero");
    wr(2'b01, 12'h341, 32'h0000_0003, "mepc_write_old");
    rd(12'h341, "mepc_bit0_cleared");

    // Reset beats a same-cycle commit.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 2'b01, 1'b0, 5'd0, 12'h340, 32'hDEAD_0000, 1'b1, "reset_with_write");
    rd(12'h340, "reset_discards_write");
    rd(12'h305, "reset_clears_mtvec");

    // Counter wrap (reads 0 when the counter is not built).
    wr(2'b01, 12'hB80, 32'h0, "mcycleh_clear");
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF, "mcycle_load");
    rd(12'hB00, "mcycle_loaded");
    rd(12'hB00, "mcycle_wrapped");
    rd(12'hB80, "mcycleh_carry");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, v, ec, mr, en, imm;
      logic [1:0] op;
      r   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 3) != 0);
      ec  = ($urandom_range(0, 9) == 0);
      mr  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      imm = ($urandom_range(0, 3) == 0);
      op  = 2'($urandom_range(1, 3));
      cycle(r, v, ec, mr, $urandom(), en, op, imm, 5'($urandom()),
            addrs[$urandom_range(0, 10)], $urandom(), 1'b1, "random");
    end

    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b01, 1'b0, 5'd0, 12'h0, 32'h0, 1'b0, "drain");
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_leftover: remaining=%0d expected=0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
